// File: rtl/manchester_pkg.sv
// Shared Manchester line-code definitions for the encoder and decoder sides.
package manchester_pkg;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // {first half-bit, second half-bit}
    localparam logic [1:0] SYM_ZERO = 2'b01;
    localparam logic [1:0] SYM_ONE  = 2'b10;

    function automatic logic is_valid_sym(input logic [1:0] sym);
        return (sym == SYM_ZERO) || (sym == SYM_ONE);
    endfunction

endpackage

// File: rtl/manchester_lock_ctrl.sv
// Symbol-lock tracker: counts consecutive valid symbols to lock and
// consecutive violations to drop lock.
module manchester_lock_ctrl #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sym_ok,
    input  logic sym_err,
    output logic locked
);
    import manchester_pkg::*;

    localparam int VW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [VW-1:0] VALID_MAX = VW'(LOCK_COUNT);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

    logic [VW-1:0] valid_cnt;
    logic [EW-1:0] err_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_cnt <= '0;
            err_cnt   <= '0;
            locked    <= 1'b0;
        end else if (sym_ok) begin
            err_cnt <= '0;
            // Counting only happens while unlocked, so valid_cnt never passes VALID_MAX
            if (!locked && (valid_cnt != VALID_MAX)) begin
                valid_cnt <= valid_cnt + 1'b1;
                if (valid_cnt + 1'b1 == VALID_MAX)
                    locked <= 1'b1;
            end
        end else if (sym_err) begin
            valid_cnt <= '0;
            if (locked) begin
                if (err_cnt == ERR_LAST) begin
                    locked  <= 1'b0;
                    err_cnt <= '0;
                end else begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/manchester_2_nrz_decoder.sv
// Manchester-to-NRZ decoder: one sample per half-bit, slips one half-bit
// on each code violation to find the symbol boundary.
//
// state     | meaning
// PH_FIRST  | next sample is the first half-bit of a symbol
// PH_SECOND | next sample completes the pair held in h1
module manchester_2_nrz_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic M_in,
    output logic B_out,
    output logic B_valid,
    output logic code_err,
    output logic locked
);
    import manchester_pkg::*;

    phase_t phase;
    logic   h1;
    logic   sym_ok;
    logic   sym_err;

    always_comb begin
        sym_ok  = 1'b0;
        sym_err = 1'b0;
        if (phase == PH_SECOND) begin
            sym_ok  = is_valid_sym({h1, M_in});
            sym_err = !sym_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase    <= PH_FIRST;
            h1       <= 1'b0;
            B_out    <= 1'b0;
            B_valid  <= 1'b0;
            code_err <= 1'b0;
        end else begin
            B_valid  <= 1'b0;
            code_err <= 1'b0;
            case (phase)
                PH_FIRST: begin
                    h1    <= M_in;
                    phase <= PH_SECOND;
                end
                PH_SECOND: begin
                    if (sym_ok) begin
                        B_out   <= h1;
                        B_valid <= 1'b1;
                        phase   <= PH_FIRST;
                    end else begin
                        // Treat this sample as the new first half-bit
                        code_err <= 1'b1;
                        h1       <= M_in;
                    end
                end
                default: phase <= PH_FIRST;
            endcase
        end
    end

    manchester_lock_ctrl #(
        .LOCK_COUNT(LOCK_COUNT),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_lock_ctrl (
        .clock  (clock),
        .reset  (reset),
        .sym_ok (sym_ok),
        .sym_err(sym_err),
        .locked (locked)
    );

endmodule

// File: tb/tb_manchester_2_nrz_decoder.sv
// Directed and randomized bench for manchester_2_nrz_decoder against a
// sample-stream reference model.
module tb_manchester_2_nrz_decoder;

    localparam int LOCK_COUNT = 4;
    localparam int ERR_LIMIT  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic M_in  = 1'b0;
    logic B_out, B_valid, code_err, locked;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   pend;      // -1: no first half-bit held, else its value
    logic m_bout, m_bvalid, m_cerr, m_locked;
    int   vrun, erun;

    manchester_2_nrz_decoder #(
        .LOCK_COUNT(LOCK_COUNT),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .M_in    (M_in),
        .B_out   (B_out),
        .B_valid (B_valid),
        .code_err(code_err),
        .locked  (locked)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        pend     = -1;
        m_bout   = 1'b0;
        m_bvalid = 1'b0;
        m_cerr   = 1'b0;
        m_locked = 1'b0;
        vrun     = 0;
        erun     = 0;
    endtask

    task automatic model_sample(input logic s);
        m_bvalid = 1'b0;
        m_cerr   = 1'b0;
        if (pend < 0) begin
            pend = int'(s);
        end else if (int'(s) != pend) begin
            m_bout   = logic'(pend[0]);
            m_bvalid = 1'b1;
            pend     = -1;
            erun     = 0;
            if (!m_locked) begin
                vrun = vrun + 1;
                if (vrun >= LOCK_COUNT) m_locked = 1'b1;
            end
        end else begin
            m_cerr = 1'b1;
            pend   = int'(s);
            vrun   = 0;
            if (m_locked) begin
                erun = erun + 1;
                if (erun >= ERR_LIMIT) begin
                    m_locked = 1'b0;
                    erun     = 0;
                end
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic s);
        reset = r;
        M_in  = s;
        @(posedge clock);
        #1;
        if (r) model_reset();
        else   model_sample(s);
        check_bit("B_out",    B_out,    m_bout);
        check_bit("B_valid",  B_valid,  m_bvalid);
        check_bit("code_err", code_err, m_cerr);
        check_bit("locked",   locked,   m_locked);
    endtask

    task automatic send_bit(input logic b);
        tick(1'b0, b);
        tick(1'b0, ~b);
    endtask

    initial begin
        model_reset();

        // reset held 3 cycles with a toggling line
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check_bit("reset_locked", locked, 1'b0);

        // aligned bits 1,0,1,1
        tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        check_bit("al_bv1", B_valid, 1'b1);
        check_bit("al_bo1", B_out, 1'b1);
        tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        check_bit("al_bo2", B_out, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        check_bit("al_unlocked3", locked, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        check_bit("al_locked4", locked, 1'b1);

        // lock loss: 0,0,0 from the first phase
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_bit("ll_cerr2", code_err, 1'b1);
        check_bit("ll_still_locked", locked, 1'b1);
        tick(1'b0, 1'b0);
        check_bit("ll_cerr3", code_err, 1'b1);
        check_bit("ll_dropped", locked, 1'b0);
        // relock: completing pair (0,1) then three more bits
        tick(1'b0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check_bit("rl_not_yet", locked, 1'b0);
        send_bit(1'b1);
        check_bit("rl_locked", locked, 1'b1);

        // single violation while locked, then another later
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        check_bit("sv_bv", B_valid, 1'b1);
        check_bit("sv_locked", locked, 1'b1);
        send_bit(1'b0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        check_bit("sv2_locked", locked, 1'b1);

        // misaligned start after reset: 1,1,0,0,1
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check_bit("ma_cerr", code_err, 1'b1);
        tick(1'b0, 1'b0);
        check_bit("ma_bo1", B_out, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_bit("ma_bv2", B_valid, 1'b1);
        check_bit("ma_bo2", B_out, 1'b0);

        // reset mid-symbol
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_bit("rm_bv", B_valid, 1'b1);
        check_bit("rm_bo", B_out, 1'b0);
        check_bit("rm_cerr", code_err, 1'b0);

        // randomized stream with stray half-bits and rare resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0)
                tick(1'b1, logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 11) == 0)
                tick(1'b0, logic'($urandom_range(0, 1)));
            send_bit(logic'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_2_nrz_decoder.md
# manchester_2_nrz_decoder

Receive-side counterpart of the NRZ-to-Manchester encoder. Samples a Manchester line once per half-bit on the system clock and recovers the NRZ bit stream. Detects code violations and re-aligns to symbol boundaries by slipping one half-bit. Reports a symbol-lock status. Sits between the line interface and the bit-level consumer (deserializer or framer).

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive valid symbols required to assert `locked`. Must be ≥1.
- ERR_LIMIT, 2: consecutive code violations while locked that drop `locked`. Must be ≥1.

Ports:
- clock  input  1  system clock, one rising edge per half-bit; the block is rising-edge only.
- reset  input  1  synchronous, active-high reset.
- M_in  input  1  Manchester line sample. Already synchronous to `clock`; no synchronizer is inside the block.
- B_out  output  1  last decoded NRZ bit. Holds its value between decodes.
- B_valid  output  1  one-cycle pulse: `B_out` was updated by a valid symbol.
- code_err  output  1  one-cycle pulse: the current pair is a code violation (00 or 11).
- locked  output  1  symbol-lock status.

## Operation
- Symbol coding: bit 0 = half-bits 0 then 1; bit 1 = half-bits 1 then 0. The decoded bit equals the first half-bit.
- Phase FSM, two states:
  - PH_FIRST: on each edge, `h1 <= M_in`; go to PH_SECOND.
  - PH_SECOND, `M_in != h1` (valid symbol): `B_out <= h1`, pulse `B_valid`; go to PH_FIRST.
  - PH_SECOND, `M_in == h1` (violation): pulse `code_err`, slip one half-bit (`h1 <= M_in`); stay in PH_SECOND.
- Lock control:
  - `valid_cnt` counts consecutive valid symbols while unlocked and saturates at LOCK_COUNT.
  - When a valid symbol brings `valid_cnt` to LOCK_COUNT, `locked <= 1` at that same edge.
  - Any violation clears `valid_cnt`.
  - While locked, each violation increments `err_cnt`. A violation that brings `err_cnt` to ERR_LIMIT sets `locked <= 0`, `err_cnt <= 0` and `valid_cnt <= 0`.
  - Any valid symbol clears `err_cnt`.
- Counter widths: `valid_cnt` is $clog2(LOCK_COUNT+1) bits; `err_cnt` is $clog2(ERR_LIMIT+1) bits. Neither counter wraps.
- Inherent limitation: a run of identical bits decodes validly at either alignment. Re-alignment only happens at the first violation. The bench must not expect detection otherwise.

## Timing
- All outputs are registered.
- Decode latency: `B_out`, `B_valid` and `code_err` change at the rising edge that samples the second half-bit. They are visible in the following cycle.
- Maximum rate: one `B_valid` every 2 cycles.
- Consecutive violations can pulse `code_err` on back-to-back cycles.
- `B_valid` and `code_err` are never high in the same cycle.
- Reset values: phase PH_FIRST; `h1`, `B_out`, `B_valid`, `code_err`, `locked`, `valid_cnt`, `err_cnt` all 0.
- Reset mid-symbol: the partial symbol is discarded. The first sample after reset deasserts is treated as a first half-bit.
- `reset` has priority over all other events in the same cycle.

## Structure
- Package `manchester_pkg` holds:
  - phase enum {PH_FIRST, PH_SECOND};
  - symbol constants SYM_ZERO = 2'b01, SYM_ONE = 2'b10.
- The encoder side imports the same package.
- One sub-module, `manchester_lock_ctrl`. Inputs: `sym_ok` and `sym_err` strobes. Output: `locked`. It owns `valid_cnt` and `err_cnt`.

## Test plan
- Reset: hold `reset` 3 cycles while `M_in` toggles → all outputs 0. First post-reset sample is taken as a first half-bit.
- Aligned stream, bits 1,0,1,1 (`M_in` = 1,0,0,1,1,0,1,0), defaults:
  - `B_valid` pulses after sample edges 2, 4, 6, 8, with `B_out` = 1, 0, 1, 1;
  - `code_err` never asserts;
  - `locked` rises with the 4th symbol.
- Misaligned start, samples 1,1,0,0,1 (one stray half-bit then bits 1, 0):
  - `code_err` pulses after edge 2;
  - `B_valid` with `B_out` = 1 after edge 3;
  - `B_valid` with `B_out` = 0 after edge 5.
- Lock loss (locked, ERR_LIMIT=2), samples 0,0,0 from PH_FIRST:
  - `code_err` pulses after edges 2 and 3;
  - `locked` falls after edge 3;
  - relock requires 4 new valid symbols.
- Single violation while locked, samples 1,1,0 then a valid symbol → `locked` stays 1 and `err_cnt` returns to 0. A later single violation does not drop lock.
- Reset mid-symbol: assert `reset` after a first half-bit of 1, then release and send bit 0 (0,1) → `B_out` = 0 with `B_valid`, and no `code_err`.
